// File: rtl/qrisc32_wb_pkg.sv
// ---------------------------------------------------------------------------
// risc_pack : definitions shared by the Qrisc32 pipeline stages.
//
//  pipe_struct_t  : the registered record handed from stage to stage.
//  REG_ADDR_W     : register address width (fixed at 5 bits).
//  NREGS_DEF      : default number of architectural registers.
//  addr_in_range  : 1 when a register address selects an implemented register.
// ---------------------------------------------------------------------------
package risc_pack;

   localparam int REG_ADDR_W = 5;
   localparam int NREGS_DEF  = 32;

   typedef struct packed {
      logic                  write_reg;       // commit val_dst into dst_r
      logic [REG_ADDR_W-1:0] dst_r;
      logic [31:0]           val_dst;
      logic                  incr_r2_enable;  // post-increment write of src_r2
      logic [REG_ADDR_W-1:0] src_r2;
      logic [31:0]           val_r2;
      logic                  write_mem;       // store, already finished in MEM
      logic                  read_mem;        // load, data arrives via val_dst
   } pipe_struct_t;

   function automatic logic addr_in_range(input logic [REG_ADDR_W-1:0] addr,
                                          input int nregs);
      return (32'(addr) < nregs);
   endfunction

endpackage

// File: rtl/qrisc32_wb_regfile.sv
// ---------------------------------------------------------------------------
// qrisc32_regfile : NREGS x 32 architectural register array.
//
//  clk, areset          clock / asynchronous active-high reset (clears all)
//  we_d, addr_d, data_d primary write port (wins on same-address collision)
//  we_i, addr_i, data_i secondary write port (post-increment results)
//  addr_a/b/c           asynchronous read addresses
//  data_a/b/c           read data; 0 for addresses with no register behind them
//
// Enables are expected to be pre-qualified by the caller; there is no bypass.
// ---------------------------------------------------------------------------
module qrisc32_regfile
   import risc_pack::*;
#(
   parameter int NREGS = NREGS_DEF
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  we_d,
   input  logic [REG_ADDR_W-1:0] addr_d,
   input  logic [31:0]           data_d,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] addr_i,
   input  logic [31:0]           data_i,
   input  logic [REG_ADDR_W-1:0] addr_a,
   input  logic [REG_ADDR_W-1:0] addr_b,
   input  logic [REG_ADDR_W-1:0] addr_c,
   output logic [31:0]           data_a,
   output logic [31:0]           data_b,
   output logic [31:0]           data_c
);

   logic [31:0] regs [NREGS];

   // Per-register write select: the if/else order gives port D priority.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (we_d && (addr_d == REG_ADDR_W'(r)))
               regs[r] <= data_d;
            else if (we_i && (addr_i == REG_ADDR_W'(r)))
               regs[r] <= data_i;
         end
      end
   end

   // Decoded read muxes so that unimplemented addresses read 0 without
   // indexing past the end of the array.
   always_comb begin
      data_a = '0;
      data_b = '0;
      data_c = '0;
      for (int r = 0; r < NREGS; r++) begin
         if (addr_a == REG_ADDR_W'(r)) data_a = regs[r];
         if (addr_b == REG_ADDR_W'(r)) data_b = regs[r];
         if (addr_c == REG_ADDR_W'(r)) data_c = regs[r];
      end
   end

endmodule

// File: rtl/qrisc32_wb.sv
// ---------------------------------------------------------------------------
// qrisc32_wb : write-back stage of the Qrisc32 pipeline.
//
//  clk, areset     clock / asynchronous active-high reset
//  pipe_wb_in      registered MEM-stage output record
//  rd_addr_a/b/c   ID-stage read addresses
//  rd_data_a/b/c   register values with write-first bypass of this cycle's
//                  writes, so ID never needs a WB hazard bubble
//  commit          registered: a register was written on the previous edge
//  commit_cnt      number of committing cycles since reset (wraps silently)
//  verbose         simulation trace of every register write; no hardware effect
//
// Parameters: NREGS implemented registers, ZERO_R0 makes r0 a constant zero.
// ---------------------------------------------------------------------------
module qrisc32_wb
   import risc_pack::*;
#(
   parameter int NREGS   = NREGS_DEF,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic                  clk,
   input  logic                  areset,
   input  pipe_struct_t          pipe_wb_in,
   input  logic [REG_ADDR_W-1:0] rd_addr_a,
   input  logic [REG_ADDR_W-1:0] rd_addr_b,
   input  logic [REG_ADDR_W-1:0] rd_addr_c,
   output logic [31:0]           rd_data_a,
   output logic [31:0]           rd_data_b,
   output logic [31:0]           rd_data_c,
   output logic                  commit,
   output logic [31:0]           commit_cnt,
   input  logic                  verbose
);

   logic        en_d;
   logic        en_i;
   logic        commit_q;
   logic [31:0] cnt_q;
   logic [31:0] reg_a, reg_b, reg_c;

   // Stores finish in MEM and loads arrive as write_reg, so these are not used.
   logic unused_mem_flags;
   assign unused_mem_flags = pipe_wb_in.write_mem ^ pipe_wb_in.read_mem;

   // Port enables: drop writes to unimplemented registers and, optionally, r0.
   always_comb begin
      en_d = pipe_wb_in.write_reg
           && addr_in_range(pipe_wb_in.dst_r, NREGS)
           && !(ZERO_R0 && (pipe_wb_in.dst_r == '0));
      en_i = pipe_wb_in.incr_r2_enable
           && addr_in_range(pipe_wb_in.src_r2, NREGS)
           && !(ZERO_R0 && (pipe_wb_in.src_r2 == '0));
   end

   // The regfile resolves the D/I collision itself (D wins).
   qrisc32_regfile #(.NREGS(NREGS)) u_regfile (
      .clk    (clk),
      .areset (areset),
      .we_d   (en_d),
      .addr_d (pipe_wb_in.dst_r),
      .data_d (pipe_wb_in.val_dst),
      .we_i   (en_i),
      .addr_i (pipe_wb_in.src_r2),
      .data_i (pipe_wb_in.val_r2),
      .addr_a (rd_addr_a),
      .addr_b (rd_addr_b),
      .addr_c (rd_addr_c),
      .data_a (reg_a),
      .data_b (reg_b),
      .data_c (reg_c)
   );

   // Read priority: unimplemented -> 0, hard-wired r0 -> 0, D bypass,
   // I bypass, then the stored value.
   function automatic logic [31:0] bypass(input logic [REG_ADDR_W-1:0] addr,
                                          input logic [31:0]           stored,
                                          input logic                  d_en,
                                          input logic                  i_en,
                                          input pipe_struct_t          p);
      if (!addr_in_range(addr, NREGS))      return '0;
      if (ZERO_R0 && (addr == '0))          return '0;
      if (d_en && (p.dst_r == addr))        return p.val_dst;
      if (i_en && (p.src_r2 == addr))       return p.val_r2;
      return stored;
   endfunction

   always_comb begin
      rd_data_a = bypass(rd_addr_a, reg_a, en_d, en_i, pipe_wb_in);
      rd_data_b = bypass(rd_addr_b, reg_b, en_d, en_i, pipe_wb_in);
      rd_data_c = bypass(rd_addr_c, reg_c, en_d, en_i, pipe_wb_in);
   end

   // A cycle with both ports writing still counts as a single commit.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         commit_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         commit_q <= en_d | en_i;
         if (en_d | en_i) cnt_q <= cnt_q + 32'd1;
      end
   end

   assign commit     = commit_q;
   assign commit_cnt = cnt_q;

   // Simulation-only write trace; a collided I write is not reported since
   // it does not reach the register.
   always @(posedge clk) begin
      if (!areset && verbose) begin
         if (en_d)
            $display("[WB stage] r%0d <= %08h%s", pipe_wb_in.dst_r,
                     pipe_wb_in.val_dst, pipe_wb_in.read_mem ? " (load)" : "");
         if (en_i && !(en_d && (pipe_wb_in.dst_r == pipe_wb_in.src_r2)))
            $display("[WB stage] r%0d <= %08h (post-increment)",
                     pipe_wb_in.src_r2, pipe_wb_in.val_r2);
      end
   end

endmodule
